fb_rect_draw: RTL

Framebuffer write engine that draws a single-colour rectangle, outline or filled, into a `bram_sdp` framebuffer. It issues one pixel write per clock on the framebuffer write port (`we`/`addr_write`/`data_in`) and sits directly upstream of the framebuffer. The display read path, CLUT and DVI output stages are unaffected. A top level starts it with a one-cycle `start` pulse, typically gated by `frame`, and waits for `done`.

---
 rtl/fb_rect_draw.sv | 221 ++++++++++++++++++++++
 1 files changed

// File: rtl/fb_rect_draw.sv
// fb_rect_draw: draws a single-colour rectangle (outline, or filled when
// FB_RECT_FILL_EN is defined) into a framebuffer, one pixel write per clock.
// Handshake: 'start' is a one-cycle request that is only sampled in IDLE.
// 'busy' is high from the cycle after the accepted start until completion.
// 'done' pulses for one cycle on completion or rejection, and 'err' is valid
// together with it.
// Optional feature macro: FB_RECT_FILL_EN (adds the 'fill' input and FILL state).
module fb_rect_draw #(
   parameter int FB_WIDTH  = 160,
   parameter int FB_HEIGHT = 120,
   parameter int CORDW     = 16,
   parameter int COLRW     = 4,
   parameter int ADDRW     = $clog2(FB_WIDTH*FB_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CORDW-1:0] x0,
   input  logic [CORDW-1:0] y0,
   input  logic [CORDW-1:0] x1,
   input  logic [CORDW-1:0] y1,
   input  logic [COLRW-1:0] cidx,
`ifdef FB_RECT_FILL_EN
   input  logic             fill,
`endif
   output logic             fb_we,
   output logic [ADDRW-1:0] fb_addr,
   output logic [COLRW-1:0] fb_cidx,
   output logic             busy,
   output logic             done,
   output logic             err,
   output logic [2:0]       dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_INIT   = 3'd1,
      S_TOP    = 3'd2,
      S_RIGHT  = 3'd3,
      S_BOTTOM = 3'd4,
      S_LEFT   = 3'd5,
      S_FILL   = 3'd6,
      S_FIN    = 3'd7
   } state_t;

   localparam logic [ADDRW-1:0] FBW_A   = ADDRW'(FB_WIDTH);
   localparam logic [CORDW-1:0] FBW_C   = CORDW'(FB_WIDTH);
   localparam logic [CORDW-1:0] FBH_C   = CORDW'(FB_HEIGHT);
   localparam logic [CORDW-1:0] ONE_C   = CORDW'(1);
   localparam logic [CORDW-1:0] TWO_C   = CORDW'(2);
   localparam logic [CORDW-1:0] THREE_C = CORDW'(3);

   state_t           r_state;
   logic             r_we;
   logic [ADDRW-1:0] r_addr;
   logic [COLRW-1:0] r_cidx;
   logic             r_busy;
   logic             r_done;
   logic             r_err;
   logic [CORDW-1:0] r_x0, r_y0, r_x1, r_y1;
   logic [CORDW-1:0] r_w, r_h;
   logic [CORDW-1:0] r_cnt;      // writes left in the current phase/row after the one on the bus
`ifdef FB_RECT_FILL_EN
   logic             r_fill;
   logic [CORDW-1:0] r_row_cnt;  // rows left after the current one
   logic [ADDRW-1:0] r_row_addr; // address of the first pixel of the current row
`endif

   logic             w_valid;
   logic [CORDW-1:0] w_w, w_h;
   logic [ADDRW-1:0] w_start;

   // Validation and geometry from the latched request; only consumed in INIT.
   assign w_valid = (r_x0 <= r_x1) && (r_y0 <= r_y1) && (r_x1 < FBW_C) && (r_y1 < FBH_C);
   assign w_w     = r_x1 - r_x0 + ONE_C;
   assign w_h     = r_y1 - r_y0 + ONE_C;
   assign w_start = ADDRW'(r_y0) * FBW_A + ADDRW'(r_x0);

   // Control FSM: each draw state holds the pixel currently on the write port
   // and steps to the next one, jumping straight into the next non-empty phase
   // so that writes stay back-to-back across corners.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_cidx  <= '0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         r_x0    <= '0;
         r_y0    <= '0;
         r_x1    <= '0;
         r_y1    <= '0;
         r_w     <= '0;
         r_h     <= '0;
         r_cnt   <= '0;
`ifdef FB_RECT_FILL_EN
         r_fill     <= 1'b0;
         r_row_cnt  <= '0;
         r_row_addr <= '0;
`endif
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_x0    <= x0;
                  r_y0    <= y0;
                  r_x1    <= x1;
                  r_y1    <= y1;
                  r_cidx  <= cidx;
`ifdef FB_RECT_FILL_EN
                  r_fill  <= fill;
`endif
                  r_busy  <= 1'b1;
                  r_err   <= 1'b0;
                  r_state <= S_INIT;
               end
            end
            S_INIT: begin
               if (!w_valid) begin
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= S_FIN;
               end else begin
                  r_w    <= w_w;
                  r_h    <= w_h;
                  r_we   <= 1'b1;
                  r_addr <= w_start;
                  r_cnt  <= w_w - ONE_C;
`ifdef FB_RECT_FILL_EN
                  r_row_addr <= w_start;
                  r_row_cnt  <= w_h - ONE_C;
                  if (r_fill) r_state <= S_FILL;
                  else
`endif
                  r_state <= S_TOP;
               end
            end
            S_TOP: begin
               if (r_cnt != '0) begin
                  r_addr <= r_addr + 1'b1;
                  r_cnt  <= r_cnt - ONE_C;
               end else if (r_h > ONE_C) begin
                  r_addr  <= r_addr + FBW_A;
                  r_cnt   <= r_h - TWO_C;
                  r_state <= S_RIGHT;
               end else begin
                  r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_FIN;
               end
            end
            S_RIGHT: begin
               if (r_cnt != '0) begin
                  r_addr <= r_addr + FBW_A;
                  r_cnt  <= r_cnt - ONE_C;
               end else if (r_w > ONE_C) begin
                  r_addr  <= r_addr - 1'b1;
                  r_cnt   <= r_w - TWO_C;
                  r_state <= S_BOTTOM;
               end else begin
                  r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_FIN;
               end
            end
            S_BOTTOM: begin
               if (r_cnt != '0) begin
                  r_addr <= r_addr - 1'b1;
                  r_cnt  <= r_cnt - ONE_C;
               end else if (r_h > TWO_C) begin
                  r_addr  <= r_addr - FBW_A;
                  r_cnt   <= r_h - THREE_C;
                  r_state <= S_LEFT;
               end else begin
                  r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_FIN;
               end
            end
            S_LEFT: begin
               if (r_cnt != '0) begin
                  r_addr <= r_addr - FBW_A;
                  r_cnt  <= r_cnt - ONE_C;
               end else begin
                  r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_FIN;
               end
            end
`ifdef FB_RECT_FILL_EN
            S_FILL: begin
               if (r_cnt != '0) begin
                  r_addr <= r_addr + 1'b1;
                  r_cnt  <= r_cnt - ONE_C;
               end else if (r_row_cnt != '0) begin
                  r_row_addr <= r_row_addr + FBW_A;
                  r_addr     <= r_row_addr + FBW_A;
                  r_cnt      <= r_w - ONE_C;
                  r_row_cnt  <= r_row_cnt - ONE_C;
               end else begin
                  r_we <= 1'b0; r_busy <= 1'b0; r_done <= 1'b1; r_state <= S_FIN;
               end
            end
`endif
            S_FIN: begin
               r_state <= S_IDLE;
            end
            default: begin
               r_we    <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign fb_we     = r_we;
   assign fb_addr   = r_addr;
   assign fb_cidx   = r_cidx;
   assign busy      = r_busy;
   assign done      = r_done;
   assign err       = r_err;
   assign dbg_state = r_state;

endmodule
